// File: rtl/dmem_responder.sv
// Data-memory responder: latches a dual-lane bundle, serializes the lanes onto a
// single-port word RAM with LAT cycles per lane, then pulses one combined response.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_ena,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_be,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ena, r_we;
  logic [AW-1:0] r_idx0, r_idx1;
  logic [63:0]   r_wdata, r_slots;
  logic [7:0]    r_be;
  logic [31:0]   r_mem [DEPTH] = '{default: '0};

  logic          w_accept, w_lane, w_last, w_we;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_wd, w_merged;
  logic [3:0]    w_be;
  logic [63:0]   w_slots_next;
  logic          w_unused;

  // Byte offset and upper address bits are deliberately dropped (word wrap).
  assign w_unused = ^{req_addr[63:AW+34], req_addr[33:32], req_addr[31:AW+2], req_addr[1:0]};

  assign w_accept = req_valid && req_ready;
  assign w_lane   = (r_state == ACC1);
  assign w_last   = ((r_state == ACC0) || (r_state == ACC1)) && (r_cnt == CW'(LAT - 1));
  assign w_idx    = w_lane ? r_idx1 : r_idx0;
  assign w_we     = r_we[w_lane];
  assign w_wd     = w_lane ? r_wdata[63:32] : r_wdata[31:0];
  assign w_be     = w_lane ? r_be[7:4] : r_be[3:0];
  assign w_word   = r_mem[w_idx];

  always_comb begin
    w_merged = w_word;
    for (int b = 0; b < 4; b++)
      if (w_be[b]) w_merged[8*b +: 8] = w_wd[8*b +: 8];
  end

  // Slots include the read landing on this edge so RESP can load them directly.
  always_comb begin
    w_slots_next = r_slots;
    if (r_state == IDLE) w_slots_next = '0;
    else if (w_last && !w_we) begin
      if (w_lane) w_slots_next[63:32] = w_word;
      else        w_slots_next[31:0]  = w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = req_ena[0] ? ACC0 : (req_ena[1] ? ACC1 : RESP);
      ACC0: if (w_last)   w_next = r_ena[1] ? ACC1 : RESP;
      ACC1: if (w_last)   w_next = RESP;
      RESP:               w_next = IDLE;
      default:            w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    busy      = !req_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      r_slots    <= '0;
    end else begin
      r_cnt      <= (w_lane || r_state == ACC0) && !w_last ? r_cnt + 1'b1 : '0;
      resp_valid <= (w_next == RESP);
      if (w_next == RESP) resp_rdata <= w_slots_next;
      r_slots    <= w_slots_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ena   <= req_ena;
      r_we    <= req_we;
      r_idx0  <= req_addr[AW+1:2];
      r_idx1  <= req_addr[AW+33:34];
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // RAM survives reset; only a write committing on a non-reset edge lands.
  always_ff @(posedge clk) begin
    if (!rst && w_last && w_we) r_mem[w_idx] <= w_merged;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps plus random bundles against
// a lane-ordered word-memory model.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 0, rst = 1, req_valid = 0;
  logic        req_ready, resp_valid, busy;
  logic [1:0]  req_ena = 0, req_we = 0;
  logic [63:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [7:0]  req_be = 0;

  int total = 0, bad = 0;
  bit [31:0] m [int];

  dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ena(req_ena), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] rd(int i);
    return m.exists(i) ? m[i] : 32'h0;
  endfunction

  // Lanes applied oldest first; loads see every earlier store.
  task automatic model(input [1:0] ena, input [1:0] we, input [63:0] addr,
                       input [63:0] wd, input [7:0] be, output [63:0] exp, output int n);
    exp = 0; n = 0;
    for (int k = 0; k < 2; k++) if (ena[k]) begin
      int idx; bit [31:0] w;
      n++;
      idx = int'((addr[32*k +: 32] / 4) % DEPTH);
      if (we[k]) begin
        w = rd(idx);
        for (int b = 0; b < 4; b++) if (be[4*k+b]) w[8*b +: 8] = wd[32*k+8*b +: 8];
        m[idx] = w;
      end else exp[32*k +: 32] = rd(idx);
    end
  endtask

  // Called #1 after the accept edge (cycle T+1).
  task automatic finish(input string tag, input [63:0] exp, input int n);
    int k = 1;
    while (!resp_valid && k < 40) begin
      check({tag, "_busy"}, busy, 1);
      @(posedge clk); #1; k++;
    end
    check({tag, "_lat"}, k, 1 + n * LAT);
    check({tag, "_rdata"}, resp_rdata, exp);
    check({tag, "_busy_resp"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, resp_valid, 0);
    check({tag, "_hold"}, resp_rdata, exp);
  endtask

  task automatic run(input string tag, input [1:0] ena, input [1:0] we, input [63:0] addr,
                     input [63:0] wd, input [7:0] be);
    logic [63:0] exp; int n;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1; req_ena = ena; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 0;
    model(ena, we, addr, wd, be, exp, n);
    finish(tag, exp, n);
  endtask

  initial begin
    logic [63:0] exp; int n;
    repeat (3) @(posedge clk); #1;
    check("rst_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy",  busy, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check("idle_valid", resp_valid, 0);

    run("st40", 2'b01, 2'b01, 64'h0000_0000_0000_0040, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    run("ld40", 2'b01, 2'b00, 64'h0000_0000_0000_0040, 64'h0, 8'h0);
    run("st80", 2'b01, 2'b01, 64'h0000_0000_0000_0080, 64'h0000_0000_1122_3344, 8'h0F);
    run("fwd",  2'b11, 2'b01, 64'h0000_0080_0000_0080, 64'h0000_0000_0000_00AA, 8'h01);
    run("ww",   2'b11, 2'b11, 64'h0000_0080_0000_0080, 64'h5566_7788_99AA_BBCC, 8'h3C);
    run("ld80", 2'b10, 2'b00, 64'h0000_0080_0000_0000, 64'h0, 8'h0);
    run("wrst", 2'b01, 2'b01, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_0005, 8'h0F);
    run("wrld", 2'b01, 2'b00, 64'h0000_0000_0000_0000, 64'h0, 8'h0);

    // Empty bundle, with a second bundle held during its busy cycle.
    @(negedge clk);
    req_valid = 1; req_ena = 2'b00; req_we = 2'b00; req_addr = 0; req_wdata = 0; req_be = 0;
    @(posedge clk); #1;
    req_ena = 2'b01; req_we = 2'b01; req_addr = 64'h200; req_wdata = 64'h77; req_be = 8'h0F;
    check("e_valid", resp_valid, 1);
    check("e_rdata", resp_rdata, 0);
    check("e_ready", req_ready, 0);
    @(posedge clk); #1;
    check("e_ready2", req_ready, 1);
    check("e_valid2", resp_valid, 0);
    @(posedge clk); #1;
    req_valid = 0;
    model(2'b01, 2'b01, 64'h200, 64'h77, 8'h0F, exp, n);
    finish("held", exp, n);
    run("ld200", 2'b01, 2'b00, 64'h200, 64'h0, 8'h0);

    // Reset during lane-1 access of a dual store.
    run("pre0", 2'b01, 2'b01, 64'h300, 64'hAAAA_0000, 8'h0F);
    run("pre1", 2'b01, 2'b01, 64'h304, 64'hBBBB_1111, 8'h0F);
    @(negedge clk);
    req_valid = 1; req_ena = 2'b11; req_we = 2'b11; req_addr = 64'h0000_0304_0000_0300;
    req_wdata = 64'h2222_2222_1111_1111; req_be = 8'hFF;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    check("r_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("r_ready", req_ready, 1);
    check("r_valid", resp_valid, 0);
    check("r_rdata", resp_rdata, 0);
    m[int'(32'h300 / 4)] = 32'h1111_1111;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("r_noresp", resp_valid, 0);
    end
    run("r_ld", 2'b11, 2'b00, 64'h0000_0304_0000_0300, 64'h0, 8'h0);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] a, d;
      a[31:0]  = {$urandom, 2'b00} & 32'hFFFF_F000 | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      a[63:32] = {$urandom, 2'b00} & 32'hFFFF_F000 | 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      run("rnd", 2'($urandom), 2'($urandom), a, d, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
